// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
// Pipeline hazard scoreboard: tracks E/M/W destination tags, picks forwarding sources and raises load-use stalls / branch flushes.
// Stall, flush and fwd_sel outputs are combinational (zero latency); counters and tags update on the rising clock edge.
module hazard_scoreboard #(
  parameter int AW  = 4,
  parameter int NRP = 4,
  parameter int NWP = 2,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_d,
  input  logic [NRP*AW-1:0] rd_addr_d,
  input  logic [NRP-1:0]    rd_used_d,
  input  logic [NWP*AW-1:0] wr_addr_d,
  input  logic [NWP-1:0]    wr_en_d,
  input  logic              is_load_d,
  input  logic              branch_taken_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [NRP*3-1:0]  fwd_sel_e,
  output logic [CW-1:0]     stall_count,
  output logic [CW-1:0]     flush_count
);

  localparam logic [AW-1:0] PC_ADDR = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Execute-stage tag
  logic              e_vld_q, e_vld_d;
  logic [NRP*AW-1:0] e_rd_addr_q, e_rd_addr_d;
  logic [NRP-1:0]    e_rd_used_q, e_rd_used_d;
  logic [NWP*AW-1:0] e_wr_addr_q, e_wr_addr_d;
  logic [NWP-1:0]    e_wr_en_q, e_wr_en_d;
  logic              e_is_load_q, e_is_load_d;

  // Memory-stage tag
  logic              m_vld_q, m_vld_d;
  logic [NWP*AW-1:0] m_wr_addr_q, m_wr_addr_d;
  logic [NWP-1:0]    m_wr_en_q, m_wr_en_d;
  logic              m_is_load_q, m_is_load_d;

  // Writeback-stage tag
  logic              w_vld_q, w_vld_d;
  logic [NWP*AW-1:0] w_wr_addr_q, w_wr_addr_d;
  logic [NWP-1:0]    w_wr_en_q, w_wr_en_d;

  logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]     flush_cnt_q, flush_cnt_d;

  logic              load_use;
  logic [AW-1:0]     e_wa0;
  logic [AW-1:0]     m_wa0, m_wa1, w_wa0, w_wa1;
  logic              m_we0, m_we1, w_we0, w_we1;

  assign e_wa0 = e_wr_addr_q[AW-1:0];
  assign m_wa0 = m_wr_addr_q[AW-1:0];
  assign w_wa0 = w_wr_addr_q[AW-1:0];
  assign m_we0 = m_wr_en_q[0];
  assign w_we0 = w_wr_en_q[0];

  // Secondary write port exists only when NWP > 1; otherwise it can never match.
  generate
    if (NWP > 1) begin : g_port1
      assign m_wa1 = m_wr_addr_q[2*AW-1:AW];
      assign w_wa1 = w_wr_addr_q[2*AW-1:AW];
      assign m_we1 = m_wr_en_q[1];
      assign w_we1 = w_wr_en_q[1];
    end else begin : g_no_port1
      assign m_wa1 = '0;
      assign w_wa1 = '0;
      assign m_we1 = 1'b0;
      assign w_we1 = 1'b0;
    end
  endgenerate

  always_comb begin
    load_use = 1'b0;
    if (issue_valid_d && e_vld_q && e_wr_en_q[0] && e_is_load_q && (e_wa0 != PC_ADDR)) begin
      for (int i = 0; i < NRP; i++) begin
        if (rd_used_d[i] && (rd_addr_d[i*AW +: AW] == e_wa0)) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // A taken branch wins over a coincident load-use hazard.
  assign stall_d = ~reset & load_use & ~branch_taken_e;
  assign stall_f = stall_d;
  assign flush_d = ~reset & branch_taken_e;
  assign flush_e = flush_d | stall_d;

  always_comb begin
    logic [AW-1:0] ra;
    logic [2:0]    sel;
    fwd_sel_e = '0;
    ra        = '0;
    sel       = 3'd0;
    for (int i = 0; i < NRP; i++) begin
      ra  = e_rd_addr_q[i*AW +: AW];
      sel = 3'd0;
      if (e_vld_q && e_rd_used_q[i] && (ra != PC_ADDR)) begin
        if (m_vld_q && m_we0 && !m_is_load_q && (m_wa0 == ra)) begin
          sel = 3'd2;
        end else if (m_vld_q && m_we1 && (m_wa1 == ra)) begin
          sel = 3'd3;
        end else if (w_vld_q && w_we0 && (w_wa0 == ra)) begin
          sel = 3'd1;
        end else if (w_vld_q && w_we1 && (w_wa1 == ra)) begin
          sel = 3'd4;
        end
      end
      fwd_sel_e[i*3 +: 3] = sel;
    end
  end

  always_comb begin
    e_vld_d     = issue_valid_d & ~flush_e;
    e_rd_addr_d = rd_addr_d;
    e_rd_used_d = rd_used_d;
    e_wr_addr_d = wr_addr_d;
    e_wr_en_d   = wr_en_d;
    e_is_load_d = is_load_d;

    m_vld_d     = e_vld_q;
    m_wr_addr_d = e_wr_addr_q;
    m_wr_en_d   = e_wr_en_q;
    m_is_load_d = e_is_load_q;

    w_vld_d     = m_vld_q;
    w_wr_addr_d = m_wr_addr_q;
    w_wr_en_d   = m_wr_en_q;
  end

  // Counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
    if (flush_d && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_vld_q     <= 1'b0;
      e_rd_addr_q <= '0;
      e_rd_used_q <= '0;
      e_wr_addr_q <= '0;
      e_wr_en_q   <= '0;
      e_is_load_q <= 1'b0;
      m_vld_q     <= 1'b0;
      m_wr_addr_q <= '0;
      m_wr_en_q   <= '0;
      m_is_load_q <= 1'b0;
      w_vld_q     <= 1'b0;
      w_wr_addr_q <= '0;
      w_wr_en_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_vld_q     <= e_vld_d;
      e_rd_addr_q <= e_rd_addr_d;
      e_rd_used_q <= e_rd_used_d;
      e_wr_addr_q <= e_wr_addr_d;
      e_wr_en_q   <= e_wr_en_d;
      e_is_load_q <= e_is_load_d;
      m_vld_q     <= m_vld_d;
      m_wr_addr_q <= m_wr_addr_d;
      m_wr_en_q   <= m_wr_en_d;
      m_is_load_q <= m_is_load_d;
      w_vld_q     <= w_vld_d;
      w_wr_addr_q <= w_wr_addr_d;
      w_wr_en_q   <= w_wr_en_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
// Bench for hazard_scoreboard: instruction-history model plus directed scenarios and randomized traffic.
module tb_hazard_scoreboard;

  localparam int AW  = 4;
  localparam int NRP = 4;
  localparam int CW  = 4;
  localparam logic [AW-1:0] PC = 4'd15;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic                    vld;
    logic [NRP-1:0][AW-1:0]  ra;
    logic [NRP-1:0]          ru;
    logic [1:0][AW-1:0]      wa;
    logic [1:0]              we;
    logic                    ld;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid_d = 1'b0;
  logic [NRP-1:0][AW-1:0] rd_addr_d = '0;
  logic [NRP-1:0] rd_used_d = '0;
  logic [1:0][AW-1:0] wr_addr_d = '0;
  logic [1:0] wr_en_d = '0;
  logic is_load_d = 1'b0;
  logic branch_taken_e = 1'b0;

  logic stall_f, stall_d, flush_d, flush_e;
  logic [NRP*3-1:0] fwd2;
  logic [CW-1:0] stall_count, flush_count;

  logic stall_f1, stall_d1, flush_d1, flush_e1;
  logic [NRP*3-1:0] fwd1;
  logic [CW-1:0] stall_count1, flush_count1;

  int n_vec = 0;
  int n_bad = 0;

  // instruction history: index 0 = E, 1 = M, 2 = W
  instr_t pipe [3];
  int m_sc, m_fc;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .NRP(NRP), .NWP(2), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .issue_valid_d(issue_valid_d),
    .rd_addr_d(rd_addr_d), .rd_used_d(rd_used_d),
    .wr_addr_d(wr_addr_d), .wr_en_d(wr_en_d), .is_load_d(is_load_d),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_sel_e(fwd2), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_scoreboard #(.AW(AW), .NRP(NRP), .NWP(1), .CW(CW)) u_dut1 (
    .clk(clk), .reset(reset), .issue_valid_d(issue_valid_d),
    .rd_addr_d(rd_addr_d), .rd_used_d(rd_used_d),
    .wr_addr_d(wr_addr_d[0]), .wr_en_d(wr_en_d[0:0]), .is_load_d(is_load_d),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1), .flush_e(flush_e1),
    .fwd_sel_e(fwd1), .stall_count(stall_count1), .flush_count(flush_count1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_load_use();
    if (!issue_valid_d || !pipe[0].vld || !pipe[0].we[0] || !pipe[0].ld || pipe[0].wa[0] == PC)
      return 1'b0;
    for (int i = 0; i < NRP; i++)
      if (rd_used_d[i] && rd_addr_d[i] == pipe[0].wa[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_stall();
    return exp_load_use() && !branch_taken_e;
  endfunction

  function automatic logic exp_flush_e();
    return branch_taken_e || exp_stall();
  endfunction

  function automatic logic [2:0] exp_fwd(input int i, input int nwp);
    int s, p;
    logic [2:0] code;
    if (!pipe[0].ru[i] || pipe[0].ra[i] == PC) return 3'd0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin s = 1; p = 0; code = 3'd2; end
        1:       begin s = 1; p = 1; code = 3'd3; end
        2:       begin s = 2; p = 0; code = 3'd1; end
        default: begin s = 2; p = 1; code = 3'd4; end
      endcase
      if (p < nwp && !(s == 1 && p == 0 && pipe[1].ld) &&
          pipe[s].vld && pipe[s].we[p] && pipe[s].wa[p] == pipe[0].ra[i])
        return code;
    end
    return 3'd0;
  endfunction

  function automatic instr_t mk_instr();
    instr_t t;
    t.vld = 1'b1;
    t.ra  = rd_addr_d;
    t.ru  = rd_used_d;
    t.wa  = wr_addr_d;
    t.we  = wr_en_d;
    t.ld  = is_load_d;
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] <= '0;
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= (issue_valid_d && !exp_flush_e()) ? mk_instr() : '0;
      if (exp_stall() && m_sc < CMAX) m_sc <= m_sc + 1;
      if (branch_taken_e && m_fc < CMAX) m_fc <= m_fc + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_stall_f", stall_f, 0);
      chk("rst_stall_d", stall_d, 0);
      chk("rst_flush_d", flush_d, 0);
      chk("rst_flush_e", flush_e, 0);
      chk("rst_fwd", fwd2, 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_flush_count", flush_count, 0);
    end else begin
      chk("stall_f", stall_f, exp_stall());
      chk("stall_d", stall_d, exp_stall());
      chk("flush_d", flush_d, branch_taken_e);
      chk("flush_e", flush_e, exp_flush_e());
      chk("stall_count", stall_count, m_sc);
      chk("flush_count", flush_count, m_fc);
      chk("nwp1_stall_d", stall_d1, exp_stall());
      if (pipe[0].vld) begin
        for (int i = 0; i < NRP; i++) begin
          chk($sformatf("fwd[%0d]", i), fwd2[i*3 +: 3], exp_fwd(i, 2));
          chk($sformatf("nwp1_fwd[%0d]", i), fwd1[i*3 +: 3], exp_fwd(i, 1));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [NRP-1:0][AW-1:0] ra, input logic [NRP-1:0] ru,
                     input logic [1:0][AW-1:0] wa, input logic [1:0] we, input logic ld, input logic br);
    issue_valid_d  = v;
    rd_addr_d      = ra;
    rd_used_d      = ru;
    wr_addr_d      = wa;
    wr_en_d        = we;
    is_load_d      = ld;
    branch_taken_e = br;
  endtask

  task automatic nop();
    put(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd3;
      3: return 4'd15;
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold;
    do_reset();

    // ADD R1, then two readers of R1 on port 0
    put(1, '0, 4'b0000, {4'd0, 4'd1}, 2'b01, 0, 0); tick();
    put(1, {4'd0, 4'd0, 4'd0, 4'd1}, 4'b0001, '0, 2'b00, 0, 0); tick();
    chk("add_fwd_m0", fwd2[2:0], 2);
    put(1, {4'd0, 4'd0, 4'd0, 4'd1}, 4'b0001, '0, 2'b00, 0, 0); tick();
    chk("add_fwd_w0", fwd2[2:0], 1);

    // LDR R2, then a reader of R2: one stall cycle, then forwarded from W
    do_reset();
    put(1, '0, 4'b0000, {4'd0, 4'd2}, 2'b01, 1, 0); tick();
    put(1, {4'd0, 4'd0, 4'd0, 4'd2}, 4'b0001, '0, 2'b00, 0, 0); #1;
    chk("ldr_stall_f", stall_f, 1);
    chk("ldr_stall_d", stall_d, 1);
    chk("ldr_flush_e", flush_e, 1);
    tick();
    chk("ldr_stall_count", stall_count, 1);
    chk("ldr_stall_gone", stall_d, 0);
    tick();
    chk("ldr_fwd_w0", fwd2[2:0], 1);

    // Long multiply R3/R4, readers of R4 on port 2
    do_reset();
    put(1, '0, 4'b0000, {4'd4, 4'd3}, 2'b11, 0, 0); tick();
    put(1, {4'd0, 4'd4, 4'd0, 4'd0}, 4'b0100, '0, 2'b00, 0, 0); tick();
    chk("mul_fwd_m1", fwd2[8:6], 3);
    chk("nwp1_mul_fwd_m1", fwd1[8:6], 0);
    tick();
    chk("mul_fwd_w1", fwd2[8:6], 4);
    chk("nwp1_mul_fwd_w1", fwd1[8:6], 0);

    // Load-use hazard coinciding with a taken branch
    do_reset();
    put(1, '0, 4'b0000, {4'd0, 4'd2}, 2'b01, 1, 0); tick();
    put(1, {4'd0, 4'd0, 4'd0, 4'd2}, 4'b0001, '0, 2'b00, 0, 1); #1;
    chk("br_flush_d", flush_d, 1);
    chk("br_flush_e", flush_e, 1);
    chk("br_stall_f", stall_f, 0);
    chk("br_stall_d", stall_d, 0);
    tick();
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 0);

    // Repeated load-use on R5: counter saturation, then async reset mid-stall
    do_reset();
    put(1, {4'd0, 4'd0, 4'd0, 4'd5}, 4'b0001, {4'd0, 4'd5}, 2'b01, 1, 0);
    repeat (2 * ((1 << CW) + 5)) tick();
    chk("sat_stall_count", stall_count, CMAX);
    tick();
    chk("sat_stall_active", stall_d, 1);
    branch_taken_e = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_stall_f", stall_f, 0);
    chk("arst_stall_d", stall_d, 0);
    chk("arst_flush_d", flush_d, 0);
    chk("arst_flush_e", flush_e, 0);
    chk("arst_stall_count", stall_count, 0);
    chk("arst_flush_count", flush_count, 0);
    chk("arst_fwd", fwd2, 0);
    branch_taken_e = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_no_stall", stall_d, 0);
    tick();
    chk("post_rst_first_in_e", stall_d, 1);

    // R15 is the PC: never forwarded, never stalls
    do_reset();
    put(1, '0, 4'b0000, {4'd0, 4'd15}, 2'b01, 0, 0); tick();
    put(1, '0, 4'b0000, {4'd0, 4'd15}, 2'b01, 1, 0); tick();
    put(1, {4'd0, 4'd0, 4'd0, 4'd15}, 4'b0001, '0, 2'b00, 0, 0); #1;
    chk("pc_no_stall", stall_d, 0);
    tick();
    chk("pc_fwd", fwd2[2:0], 0);

    // Randomized traffic; a stalled decode instruction is held
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        issue_valid_d = ($urandom_range(0, 99) < 85);
        for (int i = 0; i < NRP; i++) rd_addr_d[i] = pick();
        rd_used_d = NRP'($urandom);
        wr_addr_d[0] = pick();
        wr_addr_d[1] = pick();
        wr_en_d = 2'($urandom);
        is_load_d = ($urandom_range(0, 99) < 30);
      end
      branch_taken_e = ($urandom_range(0, 9) == 0);
      hold = exp_stall();
      tick();
    end
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
